comp_word_seq: RTL and testbench

- Sequential word comparator that sits directly downstream of the 2-bit comparator `comp`.
- It consumes one `comp` result triple (greater/lesser/equal) per accepted cycle, MSB digit first, and resolves the magnitude relation of two NDIG-digit (2*NDIG-bit) words.
- It also flags malformed (non-one-hot) comparator results.
- Upstream logic steps 2-bit digit pairs of A and B into `comp` and drives `digit_valid` alongside `comp`'s outputs.

---
 rtl/comp_word_seq.sv | 125 ++++++++++++
 tb/tb_comp_word_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/comp_word_seq.sv
// Resolves the magnitude relation of two NDIG-digit words from a stream of MSB-first comp triples.
// Flags malformed (non-one-hot) triples; done pulses one cycle after the final digit is accepted.
module comp_word_seq #(
    parameter int NDIG = 4,
    parameter int CW   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          digit_valid,
    input  logic          greater,
    input  logic          lesser,
    input  logic          equal,
    output logic          busy,
    output logic          done,
    output logic          result_gt,
    output logic          result_lt,
    output logic          result_eq,
    output logic          err,
    output logic [CW-1:0] digit_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CW-1:0] LAST_CNT = CW'(NDIG);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dec_q, dec_d;
    logic          dec_gt_q, dec_gt_d;
    logic          res_gt_q, res_gt_d;
    logic          res_lt_q, res_lt_d;
    logic          res_eq_q, res_eq_d;
    logic          err_q, err_d;
    logic          busy_q, done_q;

    logic full;
    logic one_hot;

    assign full    = (cnt_q == LAST_CNT);
    assign one_hot = $onehot({greater, lesser, equal});

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dec_d    = dec_q;
        dec_gt_d = dec_gt_q;
        res_gt_d = res_gt_q;
        res_lt_d = res_lt_q;
        res_eq_d = res_eq_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    cnt_d    = '0;
                    dec_d    = 1'b0;
                    dec_gt_d = 1'b0;
                    res_gt_d = 1'b0;
                    res_lt_d = 1'b0;
                    res_eq_d = 1'b0;
                    err_d    = 1'b0;
                end
            end
            RUN: begin
                // The cycle after the last digit publishes the decision, so done lands one edge later.
                if (full) begin
                    state_d  = DONE;
                    res_gt_d = dec_q & dec_gt_q;
                    res_lt_d = dec_q & ~dec_gt_q;
                    res_eq_d = ~dec_q;
                end else if (digit_valid) begin
                    cnt_d = cnt_q + CW'(1);
                    if (!one_hot) begin
                        err_d = 1'b1;
                    end else if (!dec_q && !equal) begin
                        dec_d    = 1'b1;
                        dec_gt_d = greater;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dec_q    <= 1'b0;
            dec_gt_q <= 1'b0;
            res_gt_q <= 1'b0;
            res_lt_q <= 1'b0;
            res_eq_q <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dec_q    <= dec_d;
            dec_gt_q <= dec_gt_d;
            res_gt_q <= res_gt_d;
            res_lt_q <= res_lt_d;
            res_eq_q <= res_eq_d;
            err_q    <= err_d;
            busy_q   <= (state_d == RUN);
            done_q   <= (state_d == DONE);
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result_gt = res_gt_q;
    assign result_lt = res_lt_q;
    assign result_eq = res_eq_q;
    assign err       = err_q;
    assign digit_cnt = cnt_q;

endmodule

// File: tb/tb_comp_word_seq.sv
// Bench for comp_word_seq: directed vector table, hand-written corner sequences, and randomized words against a word-level model.
module tb_comp_word_seq;

    localparam int NDIG = 4;
    localparam int CW   = 4;
    localparam logic [2:0] T_GT = 3'b100;
    localparam logic [2:0] T_LT = 3'b010;
    localparam logic [2:0] T_EQ = 3'b001;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, digit_valid, greater, lesser, equal;
    logic          busy, done, result_gt, result_lt, result_eq, err;
    logic [CW-1:0] digit_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    comp_word_seq #(.NDIG(NDIG), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .digit_valid(digit_valid),
        .greater(greater), .lesser(lesser), .equal(equal),
        .busy(busy), .done(done), .result_gt(result_gt), .result_lt(result_lt),
        .result_eq(result_eq), .err(err), .digit_cnt(digit_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1);
    end

    typedef struct {
        string            name;
        logic [3:0][2:0]  trip;  // trip[0] is the MSB digit
        logic [3:0][1:0]  stall; // idle cycles inserted before each digit
        logic             poke;
        logic [3:0]       exp;   // {gt, lt, eq, err}
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0][2:0] mk(input logic [2:0] d0, input logic [2:0] d1,
                                           input logic [2:0] d2, input logic [2:0] d3);
        logic [3:0][2:0] r;
        r[0] = d0; r[1] = d1; r[2] = d2; r[3] = d3;
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_word(input vec_t v);
        int k;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({v.name, "/busy_run"}, 32'(busy), 1);
        chk({v.name, "/cnt_start"}, 32'(digit_cnt), 0);
        chk({v.name, "/clr_res_err"}, 32'({result_gt, result_lt, result_eq, err}), 0);
        for (int i = 0; i < NDIG; i++) begin
            for (int s = 0; s < int'(v.stall[i]); s++) begin
                digit_valid = 1'b0;
                {greater, lesser, equal} = 3'($urandom);
                tick();
            end
            {greater, lesser, equal} = v.trip[i];
            digit_valid = 1'b1;
            if (v.poke && i == 1) start = 1'b1;
            tick();
            digit_valid = 1'b0;
            start = 1'b0;
        end
        chk({v.name, "/no_early_done"}, 32'(done), 0);
        k = 0;
        do begin
            tick();
            k++;
        end while (!done && k < 6);
        chk({v.name, "/done_latency"}, 32'(k), 1);
        chk({v.name, "/done_seen"}, 32'(done), 1);
        chk({v.name, "/busy_done"}, 32'(busy), 0);
        chk({v.name, "/result"}, 32'({result_gt, result_lt, result_eq, err}), 32'(v.exp));
        chk({v.name, "/cnt_final"}, 32'(digit_cnt), NDIG);
        if (v.poke) begin
            start = 1'b1;
            digit_valid = 1'b1;
            {greater, lesser, equal} = T_GT;
        end
        tick();
        start = 1'b0;
        chk({v.name, "/done_one_cycle"}, 32'(done), 0);
        chk({v.name, "/idle_busy"}, 32'(busy), 0);
        if (v.poke) begin
            for (int j = 0; j < 3; j++) tick();
            digit_valid = 1'b0;
            chk({v.name, "/idle_ignores"}, 32'({busy, done, digit_cnt}), 32'(NDIG));
        end
        chk({v.name, "/held"}, 32'({result_gt, result_lt, result_eq, err, digit_cnt}),
            32'({v.exp, 4'(NDIG)}));
    endtask

    // Word-level reference: clean words compare as integers; malformed digits neither decide nor count as equal-forcing.
    function automatic logic [3:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] bad, input logic [3:0][2:0] trip);
        logic [3:0] r;
        if (bad == 4'b0) begin
            r = {a > b, a < b, a == b, 1'b0};
        end else begin
            r = {3'b001, 1'b1};
            for (int i = 0; i < NDIG; i++) begin
                if (!bad[i] && trip[i] != T_EQ) begin
                    r = {trip[i] == T_GT, trip[i] == T_LT, 1'b0, 1'b1};
                    break;
                end
            end
        end
        return r;
    endfunction

    vec_t vecs[8];
    logic [2:0] malformed[5];

    initial begin
        rst = 1'b1;
        start = 1'b0; digit_valid = 1'b0; greater = 1'b0; lesser = 1'b0; equal = 1'b0;
        malformed[0] = 3'b000; malformed[1] = 3'b011; malformed[2] = 3'b101;
        malformed[3] = 3'b110; malformed[4] = 3'b111;

        vecs[0] = '{"gt_3rd",   mk(T_EQ, T_EQ, T_GT, T_LT),   '0,        1'b0, 4'b1000};
        vecs[1] = '{"eq_stall", mk(T_EQ, T_EQ, T_EQ, T_EQ),   8'h14,     1'b0, 4'b0010};
        vecs[2] = '{"msb_prio", mk(T_LT, T_GT, T_GT, T_GT),   '0,        1'b0, 4'b0100};
        vecs[3] = '{"bad_111",  mk(T_EQ, 3'b111, T_EQ, T_EQ), '0,        1'b0, 4'b0011};
        vecs[4] = '{"ignored",  mk(T_GT, T_LT, T_EQ, T_EQ),   8'h41,     1'b1, 4'b1000};
        vecs[5] = '{"lt_last",  mk(T_EQ, T_EQ, T_EQ, T_LT),   8'h22,     1'b0, 4'b0100};
        vecs[6] = '{"bad_000",  mk(3'b000, T_GT, T_LT, T_EQ), '0,        1'b0, 4'b1001};
        vecs[7] = '{"bad_late", mk(T_LT, T_EQ, 3'b110, T_GT), '0,        1'b0, 4'b0101};

        repeat (3) tick();
        chk("reset_held", 32'({busy, done, result_gt, result_lt, result_eq, err, digit_cnt}), 0);
        rst = 1'b0;
        tick();
        chk("reset_release", 32'({busy, done, result_gt, result_lt, result_eq, err, digit_cnt}), 0);

        for (int i = 0; i < 8; i++) run_word(vecs[i]);

        // Abort mid-comparison after two digits.
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        digit_valid = 1'b1;
        {greater, lesser, equal} = T_EQ;
        tick();
        {greater, lesser, equal} = 3'b111;
        tick();
        digit_valid = 1'b0;
        chk("pre_reset_cnt", 32'({busy, digit_cnt}), 32'({1'b1, 4'd2}));
        rst = 1'b1;
        #1;
        chk("reset_midrun", 32'({busy, done, result_gt, result_lt, result_eq, err, digit_cnt}), 0);
        tick();
        rst = 1'b0;
        for (int j = 0; j < 6; j++) begin
            tick();
            chk("no_done_after_abort", 32'({busy, done}), 0);
        end
        run_word(vecs[0]);

        for (int n = 0; n < 40; n++) begin
            vec_t       v;
            logic [7:0] a, b;
            logic [3:0] bad;
            a = 8'($urandom);
            b = ($urandom_range(0, 3) == 0) ? a : 8'($urandom);
            bad = '0;
            for (int i = 0; i < NDIG; i++) begin
                logic [1:0] da, db;
                da = a[7-2*i -: 2];
                db = b[7-2*i -: 2];
                v.trip[i] = (da > db) ? T_GT : (da < db) ? T_LT : T_EQ;
                if ($urandom_range(0, 5) == 0) begin
                    bad[i] = 1'b1;
                    v.trip[i] = malformed[$urandom_range(0, 4)];
                end
                v.stall[i] = 2'($urandom_range(0, 2));
            end
            v.name = $sformatf("rnd%0d", n);
            v.poke = 1'($urandom_range(0, 1));
            v.exp  = model(a, b, bad, v.trip);
            run_word(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
